ifu_fetch: RTL and testbench
============================

IFU_FETCH -- requirements
Module: ifu_fetch

Interface
REQ-001 SHALL have parameter DW, default 64, meaning data/address width; legal values 32 or 64.
REQ-002 SHALL have parameter TMO, default 1023, meaning the maximum cycles spent waiting for read data.
REQ-003 SHALL have one clock and reset; reset is asynchronous and active-low.
- clk  in  1  clock, rising edge
- rstn  in  1  asynchronous active-low reset
REQ-004 SHALL have these ports:
- pc  in  DW  current PC from PC generator
- pc_ld  out  1  one-cycle load strobe to PC generator
- exe_done  in  1  back-end finished current instruction
- inst  out  32  fetched instruction
- inst_valid  out  1  inst holds a valid instruction
- fetch_err  out  1  sticky fault flag
- err_cause  out  2  0 none, 1 misaligned, 2 bus resp, 3 timeout
- imem_arvalid  out  1  read address valid
- imem_araddr  out  DW  read address
- imem_arready  in  1  address accepted
- imem_rvalid  in  1  read data valid
- imem_rdata  in  DW  read data
- imem_rresp  in  2  read response, 0 = OKAY
- imem_rready  out  1  ready for read data

Function
REQ-005 SHALL implement FSM states BOOT, AR, R, EXEC, ERR.
REQ-006 BOOT SHALL assert pc_ld for exactly one cycle, then go to AR; this advances the PC from its reset value, entry-4, to the entry PC.
REQ-007 On entering AR, a pc with pc[1:0] != 0 SHALL go to ERR with cause 1 and SHALL issue no request.
REQ-008 Otherwise AR SHALL:
- assert imem_arvalid with imem_araddr = pc & ~7 for DW=64, or pc & ~3 for DW=32;
- hold the address stable until imem_arready;
- move to R on the cycle arvalid and arready are both high.
REQ-009 R SHALL assert imem_rready. On imem_rvalid it SHALL capture the instruction:
- DW=64: inst = pc[2] ? rdata[63:32] : rdata[31:0];
- DW=32: inst = rdata[31:0].
REQ-010 The R exit on imem_rvalid SHALL depend on imem_rresp:
- rresp = 0: go to EXEC;
- rresp != 0: go to ERR with cause 2, inst not updated.
REQ-011 A wait counter SHALL clear on entry to R and increment each cycle in R without rvalid.
REQ-012 When the wait counter reaches TMO, the FSM SHALL go to ERR with cause 3; rvalid arriving in that same cycle SHALL take precedence, giving a normal capture.
REQ-013 EXEC SHALL hold inst_valid=1 and inst stable.
REQ-014 When exe_done is high in EXEC, pc_ld SHALL be asserted combinationally in that same cycle, and the next state SHALL be AR (fetch of the new PC next cycle).
REQ-015 exe_done outside EXEC SHALL be ignored.
REQ-016 pc_ld SHALL be high only in BOOT or in EXEC with exe_done; never two consecutive cycles.
REQ-017 ERR SHALL be terminal until reset:
- fetch_err=1, err_cause held;
- arvalid, rready, inst_valid and pc_ld all 0.
REQ-018 Fetch latency SHALL be exactly 2 cycles (AR -> R -> EXEC) when arready and rvalid are each high on first assertion.
REQ-019 imem_arvalid SHALL never deassert before its handshake completes.
REQ-020 Read data SHALL be accepted only in R; rvalid seen in AR SHALL be ignored.

Reset
REQ-021 While rstn=0, the block SHALL be:
- state BOOT, wait counter 0;
- inst=0, inst_valid=0, fetch_err=0, err_cause=0;
- imem_arvalid=0, imem_rready=0, pc_ld=0.
REQ-022 Reset asserted mid-transaction SHALL abandon it immediately; after release, the first action SHALL be the BOOT pc_ld pulse.
REQ-023 pc_ld SHALL NOT assert while rstn=0.

Structure
REQ-024 A shared package SHALL hold:
- the FSM state enum;
- err_cause encodings;
- RESP_OKAY = 2'b00;
- the NOP encoding 32'h0000_0013.
REQ-025 The wait counter with TMO compare SHALL be the sub-module ifu_wdt (inputs clr, en; output expired); all other logic stays in ifu_fetch.

Verification
REQ-026 Reset release, pc=0x7FFF_FFFC:
- one pc_ld pulse;
- then arvalid with araddr=0x8000_0000.
REQ-027 pc=0x8000_0004, DW=64, rdata=0x0010_0093_0000_0013, zero-wait memory:
- inst=0x0010_0093, inst_valid 2 cycles after AR entry;
- exe_done pulse -> same-cycle pc_ld.
REQ-028 arready delayed 3 cycles, rvalid delayed 5:
- araddr stable throughout;
- inst_valid only after rvalid;
- no pc_ld during the wait.
REQ-029 rresp=2'b10 on rvalid -> fetch_err=1, err_cause=2, no further arvalid or pc_ld.
REQ-030 TMO=8 with rvalid never asserted -> err_cause=3 after 8 cycles in R; a second run with rvalid in cycle 8 -> normal EXEC.
REQ-031 pc=0x8000_0002 -> err_cause=1, arvalid never asserted; then rstn pulsed low mid-state -> clean BOOT restart.

Source files
------------

// File: rtl/ifu_fetch_pkg.sv
`default_nettype none
// ============================================================================
// ifu_fetch_pkg : shared state, error-cause and bus encodings for the fetch unit
// Revision      : 1.0
// ============================================================================
package ifu_fetch_pkg;

  typedef enum logic [2:0] {
    S_BOOT = 3'd0,
    S_AR   = 3'd1,
    S_R    = 3'd2,
    S_EXEC = 3'd3,
    S_ERR  = 3'd4
  } fetch_state_e;

  localparam logic [1:0]  CAUSE_NONE     = 2'd0;
  localparam logic [1:0]  CAUSE_MISALIGN = 2'd1;
  localparam logic [1:0]  CAUSE_BUS      = 2'd2;
  localparam logic [1:0]  CAUSE_TMO      = 2'd3;

  localparam logic [1:0]  RESP_OKAY      = 2'b00;
  localparam logic [31:0] NOP_INST       = 32'h0000_0013;

endpackage
`default_nettype wire

// File: rtl/ifu_fetch_if.sv
`default_nettype none
// ============================================================================
// ifu_fetch_if : instruction-memory read channel (address + data phases)
// Revision     : 1.0
// ============================================================================
interface ifu_fetch_if #(
  parameter int DW = 64
);
  logic          arvalid;
  logic [DW-1:0] araddr;
  logic          arready;
  logic          rvalid;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;
  logic          rready;

  modport master (
    output arvalid, araddr, rready,
    input  arready, rvalid, rdata, rresp
  );

  modport slave (
    input  arvalid, araddr, rready,
    output arready, rvalid, rdata, rresp
  );
endinterface
`default_nettype wire

// File: rtl/ifu_wdt.sv
`default_nettype none
// ============================================================================
// ifu_wdt : read-data wait counter with timeout detection
// Revision: 1.0
// ============================================================================
module ifu_wdt #(
  parameter int TMO = 1023
) (
  input  wire logic clk,
  input  wire logic rstn,
  input  wire logic clr,
  input  wire logic en,
  output logic      expired
);
  localparam int CW = (TMO < 2) ? 1 : $clog2(TMO);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // Fires on the idle cycle whose increment brings the count to TMO.
  assign expired = en && (r_cnt == CW'(TMO - 1));

endmodule
`default_nettype wire

// File: rtl/ifu_fetch.sv
`default_nettype none
// ============================================================================
// ifu_fetch : single-outstanding instruction fetch FSM with sticky fault report
// Revision  : 1.0
// ============================================================================
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter int DW  = 64,
  parameter int TMO = 1023
) (
  input  wire logic          clk,
  input  wire logic          rstn,
  input  wire logic [DW-1:0] pc,
  output logic               pc_ld,
  input  wire logic          exe_done,
  output logic [31:0]        inst,
  output logic               inst_valid,
  output logic               fetch_err,
  output logic [1:0]         err_cause,
  ifu_fetch_if.master        imem
);

  fetch_state_e  r_state;
  fetch_state_e  w_next;
  logic          r_live;
  logic [31:0]   r_inst;
  logic [1:0]    r_cause;
  logic [1:0]    w_cause;
  logic          w_cause_we;
  logic          w_capture;
  logic          w_aligned;
  logic          w_expired;
  logic [DW-1:0] w_addr;
  logic [31:0]   w_word;

  generate
    if (DW == 64) begin : g_dw64
      assign w_addr = {pc[DW-1:3], 3'b000};
      assign w_word = pc[2] ? imem.rdata[63:32] : imem.rdata[31:0];
    end else begin : g_dw32
      assign w_addr = {pc[DW-1:2], 2'b00};
      assign w_word = imem.rdata[31:0];
    end
  endgenerate

  assign w_aligned = (pc[1:0] == 2'b00);

  ifu_wdt #(.TMO(TMO)) u_wdt (
    .clk     (clk),
    .rstn    (rstn),
    .clr     (r_state == S_AR),
    .en      ((r_state == S_R) && !imem.rvalid),
    .expired (w_expired)
  );

  // r_live holds BOOT silent for the first cycle after release so pc_ld never
  // depends on the asynchronous reset pin itself.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_BOOT;
      r_live  <= 1'b0;
      r_inst  <= '0;
      r_cause <= CAUSE_NONE;
    end else begin
      r_state <= w_next;
      r_live  <= 1'b1;
      if (w_capture)  r_inst  <= w_word;
      if (w_cause_we) r_cause <= w_cause;
    end
  end

  always_comb begin
    w_next     = r_state;
    pc_ld      = 1'b0;
    w_cause    = CAUSE_NONE;
    w_cause_we = 1'b0;
    w_capture  = 1'b0;
    case (r_state)
      S_BOOT: begin
        if (r_live) begin
          pc_ld  = 1'b1;
          w_next = S_AR;
        end
      end
      S_AR: begin
        if (!w_aligned) begin
          w_next     = S_ERR;
          w_cause    = CAUSE_MISALIGN;
          w_cause_we = 1'b1;
        end else if (imem.arready) begin
          w_next = S_R;
        end
      end
      S_R: begin
        if (imem.rvalid) begin
          if (imem.rresp == RESP_OKAY) begin
            w_capture = 1'b1;
            w_next    = S_EXEC;
          end else begin
            w_next     = S_ERR;
            w_cause    = CAUSE_BUS;
            w_cause_we = 1'b1;
          end
        end else if (w_expired) begin
          w_next     = S_ERR;
          w_cause    = CAUSE_TMO;
          w_cause_we = 1'b1;
        end
      end
      S_EXEC: begin
        if (exe_done) begin
          pc_ld  = 1'b1;
          w_next = S_AR;
        end
      end
      S_ERR:   w_next = S_ERR;
      default: w_next = S_BOOT;
    endcase
  end

  assign imem.arvalid = (r_state == S_AR) && w_aligned;
  assign imem.araddr  = w_addr;
  assign imem.rready  = (r_state == S_R);

  assign inst       = r_inst;
  assign inst_valid = (r_state == S_EXEC);
  assign fetch_err  = (r_state == S_ERR);
  assign err_cause  = r_cause;

endmodule
`default_nettype wire

// File: tb/tb_ifu_fetch.sv
`default_nettype none
// ============================================================================
// tb_ifu_fetch : directed self-checking bench for ifu_fetch (DW=64, TMO=8)
// Revision     : 1.0
// ============================================================================
module tb_ifu_fetch;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [DW-1:0] pc;
  logic [DW-1:0] rst_pc = 64'h7FFF_FFFC;
  logic [DW-1:0] nxt_pc = 64'h8000_0000;
  logic          pc_ld;
  logic          exe_done = 1'b0;
  logic [31:0]   inst;
  logic          inst_valid;
  logic          fetch_err;
  logic [1:0]    err_cause;
  int            n_chk  = 0;
  int            n_pass = 0;

  ifu_fetch_if #(.DW(DW)) imem_bus ();

  ifu_fetch #(.DW(DW), .TMO(8)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .pc         (pc),
    .pc_ld      (pc_ld),
    .exe_done   (exe_done),
    .inst       (inst),
    .inst_valid (inst_valid),
    .fetch_err  (fetch_err),
    .err_cause  (err_cause),
    .imem       (imem_bus)
  );

  always #5 clk = ~clk;

  // PC generator model: reset value, then the queued next PC on each load strobe.
  always @(posedge clk or negedge rstn) begin
    if (!rstn)      pc <= rst_pc;
    else if (pc_ld) pc <= nxt_pc;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [63:0] rpc, input logic [63:0] npc);
    rst_pc = rpc;
    nxt_pc = npc;
    exe_done = 1'b0;
    imem_bus.arready = 1'b0;
    imem_bus.rvalid  = 1'b0;
    imem_bus.rresp   = 2'b00;
    imem_bus.rdata   = '0;
    rstn = 1'b0;
    #1;
    step();
    step();
    check("rst_inst",    inst, 0);
    check("rst_ivalid",  inst_valid, 0);
    check("rst_err",     fetch_err, 0);
    check("rst_cause",   err_cause, 0);
    check("rst_arvalid", imem_bus.arvalid, 0);
    check("rst_rready",  imem_bus.rready, 0);
    check("rst_pcld",    pc_ld, 0);
    rstn = 1'b1;
    #1;
    check("pcld_pre", pc_ld, 0);
    step();
    check("boot_pcld",    pc_ld, 1);
    check("boot_arvalid", imem_bus.arvalid, 0);
    step();
    check("boot_pcld_once", pc_ld, 0);
  endtask

  initial begin
    imem_bus.arready = 1'b0;
    imem_bus.rvalid  = 1'b0;
    imem_bus.rresp   = 2'b00;
    imem_bus.rdata   = '0;

    // Boot from 0x7FFF_FFFC: one load strobe, then a request at 0x8000_0000.
    do_reset(64'h7FFF_FFFC, 64'h8000_0000);
    check("boot_arvalid_on", imem_bus.arvalid, 1);
    check("boot_araddr", imem_bus.araddr, 64'h8000_0000);

    // Slow slave: arready after 3 cycles, stray rvalid during AR, rvalid after 5.
    imem_bus.rvalid = 1'b1;
    imem_bus.rdata  = 64'hDEAD_BEEF_DEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      check("ar_wait_valid", imem_bus.arvalid, 1);
      check("ar_wait_addr",  imem_bus.araddr, 64'h8000_0000);
      check("ar_wait_pcld",  pc_ld, 0);
      step();
    end
    imem_bus.rvalid  = 1'b0;
    imem_bus.arready = 1'b1;
    #1;
    check("ar_hs_valid", imem_bus.arvalid, 1);
    step();
    imem_bus.arready = 1'b0;
    imem_bus.rdata   = 64'h0010_0093_0000_0013;
    check("r_inst_hold", inst, 0);
    for (int i = 0; i < 5; i++) begin
      check("r_wait_rready", imem_bus.rready, 1);
      check("r_wait_ivalid", inst_valid, 0);
      check("r_wait_pcld",   pc_ld, 0);
      check("r_wait_arvalid", imem_bus.arvalid, 0);
      step();
    end
    imem_bus.rvalid = 1'b1;
    step();
    imem_bus.rvalid = 1'b0;
    check("slow_inst",   inst, 32'h0000_0013);
    check("slow_ivalid", inst_valid, 1);
    step();
    check("exec_hold_inst", inst, 32'h0000_0013);
    check("exec_hold_vld",  inst_valid, 1);
    check("exec_no_pcld",   pc_ld, 0);
    nxt_pc = 64'h8000_0004;
    exe_done = 1'b1;
    #1;
    check("exec_pcld", pc_ld, 1);
    step();
    check("ar_pcld_once", pc_ld, 0);
    exe_done = 1'b0;

    // Zero-wait fetch of 0x8000_0004: upper word selected, EXEC two cycles later.
    check("zw_arvalid", imem_bus.arvalid, 1);
    check("zw_araddr",  imem_bus.araddr, 64'h8000_0000);
    imem_bus.arready = 1'b1;
    imem_bus.rvalid  = 1'b1;
    imem_bus.rdata   = 64'h0010_0093_0000_0013;
    step();
    imem_bus.arready = 1'b0;
    check("zw_rready", imem_bus.rready, 1);
    check("zw_ivalid_r", inst_valid, 0);
    step();
    imem_bus.rvalid = 1'b0;
    check("zw_inst",   inst, 32'h0010_0093);
    check("zw_ivalid", inst_valid, 1);
    nxt_pc = 64'h8000_0008;
    exe_done = 1'b1;
    #1;
    check("zw_pcld", pc_ld, 1);
    step();
    exe_done = 1'b0;

    // Bus error response on 0x8000_0008.
    imem_bus.arready = 1'b1;
    step();
    imem_bus.arready = 1'b0;
    imem_bus.rvalid  = 1'b1;
    imem_bus.rresp   = 2'b10;
    imem_bus.rdata   = '1;
    step();
    imem_bus.rvalid = 1'b0;
    imem_bus.rresp  = 2'b00;
    check("bus_err",    fetch_err, 1);
    check("bus_cause",  err_cause, 2);
    check("bus_inst",   inst, 32'h0010_0093);
    check("bus_ivalid", inst_valid, 0);
    exe_done = 1'b1;
    imem_bus.arready = 1'b1;
    imem_bus.rvalid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("err_arvalid", imem_bus.arvalid, 0);
      check("err_pcld",    pc_ld, 0);
      check("err_rready",  imem_bus.rready, 0);
      check("err_cause",   err_cause, 2);
      step();
    end
    exe_done = 1'b0;
    imem_bus.arready = 1'b0;
    imem_bus.rvalid  = 1'b0;

    // Timeout: no rvalid, ERR after exactly 8 cycles in R.
    do_reset(64'h8000_000C, 64'h8000_0010);
    imem_bus.arready = 1'b1;
    step();
    imem_bus.arready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("tmo_wait_err", fetch_err, 0);
      check("tmo_wait_rready", imem_bus.rready, 1);
      step();
    end
    check("tmo_err",   fetch_err, 1);
    check("tmo_cause", err_cause, 3);

    // rvalid in the 8th R cycle wins over the timeout; exe_done in R is ignored.
    do_reset(64'h8000_0010, 64'h8000_0014);
    imem_bus.arready = 1'b1;
    step();
    imem_bus.arready = 1'b0;
    exe_done = 1'b1;
    for (int i = 0; i < 7; i++) begin
      check("r_exe_ignored", pc_ld, 0);
      step();
    end
    exe_done = 1'b0;
    imem_bus.rvalid = 1'b1;
    imem_bus.rdata  = {32'h1234_5678, 32'h0000_0013};
    step();
    imem_bus.rvalid = 1'b0;
    check("late_ivalid", inst_valid, 1);
    check("late_err",    fetch_err, 0);
    check("late_inst",   inst, 32'h1234_5678);

    // Misaligned PC: no request, cause 1; async reset then clean restart.
    do_reset(64'h7FFF_FFFE, 64'h8000_0002);
    check("mis_arvalid_ar", imem_bus.arvalid, 0);
    step();
    check("mis_err",     fetch_err, 1);
    check("mis_cause",   err_cause, 1);
    check("mis_arvalid", imem_bus.arvalid, 0);
    rstn = 1'b0;
    #1;
    check("async_err",   fetch_err, 0);
    check("async_cause", err_cause, 0);
    check("async_pcld",  pc_ld, 0);
    do_reset(64'h7FFF_FFFC, 64'h8000_0000);
    check("restart_arvalid", imem_bus.arvalid, 1);
    check("restart_araddr",  imem_bus.araddr, 64'h8000_0000);

    // Reset in the middle of a read abandons it at once.
    imem_bus.arready = 1'b1;
    step();
    imem_bus.arready = 1'b0;
    check("mid_rready", imem_bus.rready, 1);
    rstn = 1'b0;
    #1;
    check("mid_rst_rready",  imem_bus.rready, 0);
    check("mid_rst_arvalid", imem_bus.arvalid, 0);
    check("mid_rst_pcld",    pc_ld, 0);
    do_reset(64'h7FFF_FFFC, 64'h8000_0000);
    check("mid_restart_addr", imem_bus.araddr, 64'h8000_0000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
